ram_access_arbiter: RTL and testbench

Synchronous two-requester controller for the 16x8 asynchronous single-port RAM with a bidirectional data bus. It accepts read/write commands from two client ports (A and B), arbitrates between them and latches the winning command. It then sequences the RAM's level-sensitive `we_in`/`enable_in` strobes and the tri-state data bus, so the RAM sees glitch-free, contention-free accesses. It sits between the RAM and the clocked logic that uses it; the RAM itself is unchanged.

---
 rtl/ram_arb_pkg.sv | 24 ++
 rtl/ram_arb_rr2.sv | 44 ++++
 rtl/ram_access_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants for the RAM access arbiter: widths, FSM state codes, client IDs.
package ram_arb_pkg;

    localparam int unsigned RAM_ADDR_WIDTH = 4;
    localparam int unsigned RAM_DATA_WIDTH = 8;
    localparam int unsigned STATE_WIDTH    = 3;

    // Access sequencer states: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE
    localparam logic [STATE_WIDTH-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_WIDTH-1:0] ST_SETUP  = 3'd1;
    localparam logic [STATE_WIDTH-1:0] ST_STROBE = 3'd2;
    localparam logic [STATE_WIDTH-1:0] ST_HOLD   = 3'd3;
    localparam logic [STATE_WIDTH-1:0] ST_DONE   = 3'd4;

    // Client IDs double as the bit index into the arbiter req/grant vectors
    localparam logic CLIENT_A = 1'b0;
    localparam logic CLIENT_B = 1'b1;

    // States in which a write keeps the data bus driven
    function automatic logic is_bus_phase(input logic [STATE_WIDTH-1:0] st);
        return (st == ST_SETUP) || (st == ST_STROBE) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way request arbiter with one-hot grant.
// RAM_ARB_RR_EN defined: round-robin with a pointer register (reset favours A).
// RAM_ARB_RR_EN undefined: fixed priority, A wins every tie, no pointer state.
module ram_arb_rr2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef RAM_ARB_RR_EN
    logic ptr_q;
    logic ptr_d;

    // Tie-break by pointer; after each accept favour the client that lost
    always_comb begin
        grant = req;
        ptr_d = ptr_q;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
        if (accept && (grant != 2'b00)) begin
            ptr_d = grant[0];
        end
    end

    // Pointer register: 0 favours A, 1 favours B
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_ok;

    // Fixed priority: B only when A is not requesting
    assign grant     = {req[1] & ~req[0], req[0]};
    assign unused_ok = ^{clock, reset, accept};
`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// Two-client controller for the 16x8 async single-port RAM. Arbitrates A/B
// commands, latches the winner and sequences we/enable and the tri-state bus
// so every RAM access is glitch-free and contention-free.
// Arbitration mode selected by RAM_ARB_RR_EN (handled inside ram_arb_rr2).
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_a_in,
    input  logic                  req_b_in,
    input  logic                  we_a_in,
    input  logic                  we_b_in,
    input  logic [ADDR_WIDTH-1:0] addr_a_in,
    input  logic [ADDR_WIDTH-1:0] addr_b_in,
    input  logic [DATA_WIDTH-1:0] wdata_a_in,
    input  logic [DATA_WIDTH-1:0] wdata_b_in,
    output logic                  gnt_a_out,
    output logic                  gnt_b_out,
    output logic                  done_a_out,
    output logic                  done_b_out,
    output logic [DATA_WIDTH-1:0] rdata_a_out,
    output logic [DATA_WIDTH-1:0] rdata_b_out,
    output logic                  ram_we_out,
    output logic                  ram_enable_out,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   cmd_we_q, cmd_we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   gnt_a_q, gnt_a_d;
    logic                   gnt_b_q, gnt_b_d;
    logic                   done_a_q, done_a_d;
    logic                   done_b_q, done_b_d;
    logic                   ram_we_q, ram_we_d;
    logic                   ram_en_q, ram_en_d;
    logic                   drive_q, drive_d;
    logic [DATA_WIDTH-1:0]  rdata_a_q, rdata_a_d;
    logic [DATA_WIDTH-1:0]  rdata_b_q, rdata_b_d;
    logic [1:0]             grant;
    logic                   accept_c;

    // Requests are only considered while idle
    assign accept_c = (state_q == ST_IDLE) && (req_a_in || req_b_in);

    ram_arb_rr2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    ({req_b_in, req_a_in}),
        .accept (accept_c),
        .grant  (grant)
    );

    // Next state and command latch: load the winner's command on accept
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cmd_we_d = cmd_we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_SETUP;
                    if (grant == 2'b10) begin
                        owner_d  = CLIENT_B;
                        cmd_we_d = we_b_in;
                        addr_d   = addr_b_in;
                        wdata_d  = wdata_b_in;
                    end else begin
                        owner_d  = CLIENT_A;
                        cmd_we_d = we_a_in;
                        addr_d   = addr_a_in;
                        wdata_d  = wdata_a_in;
                    end
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_HOLD;
            ST_HOLD:   state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so every RAM/client output is a flop
    always_comb begin
        gnt_a_d   = (state_d != ST_IDLE) && (owner_d == CLIENT_A);
        gnt_b_d   = (state_d != ST_IDLE) && (owner_d == CLIENT_B);
        done_a_d  = (state_d == ST_DONE) && (owner_d == CLIENT_A);
        done_b_d  = (state_d == ST_DONE) && (owner_d == CLIENT_B);
        ram_we_d  = (state_d == ST_STROBE) && cmd_we_d;
        ram_en_d  = (state_d == ST_STROBE) && !cmd_we_d;
        drive_d   = cmd_we_d && is_bus_phase(state_d);
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        // Read data sampled at the edge that ends the enable strobe
        if ((state_q == ST_STROBE) && !cmd_we_q) begin
            if (owner_q == CLIENT_B) begin
                rdata_b_d = ram_data;
            end else begin
                rdata_a_d = ram_data;
            end
        end
    end

    // State, command and output registers; reset aborts any access in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= CLIENT_A;
            cmd_we_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            ram_en_q  <= 1'b0;
            drive_q   <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cmd_we_q  <= cmd_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            ram_we_q  <= ram_we_d;
            ram_en_q  <= ram_en_d;
            drive_q   <= drive_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign gnt_a_out      = gnt_a_q;
    assign gnt_b_out      = gnt_b_q;
    assign done_a_out     = done_a_q;
    assign done_b_out     = done_b_q;
    assign rdata_a_out    = rdata_a_q;
    assign rdata_b_out    = rdata_b_q;
    assign ram_we_out     = ram_we_q;
    assign ram_enable_out = ram_en_q;
    assign ram_addr_out   = addr_q;

    // Bus driven only for writes in SETUP/STROBE/HOLD
    assign ram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural 16x8 async RAM.
module tb_ram_access_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_a_in, req_b_in, we_a_in, we_b_in;
    logic [AW-1:0] addr_a_in, addr_b_in;
    logic [DW-1:0] wdata_a_in, wdata_b_in;
    logic          gnt_a_out, gnt_b_out, done_a_out, done_b_out;
    logic [DW-1:0] rdata_a_out, rdata_b_out;
    logic          ram_we_out, ram_enable_out;
    logic [AW-1:0] ram_addr_out;
    wire  [DW-1:0] ram_data;

    logic          probe_en = 1'b0;
    logic [DW-1:0] mem [16];
    int            tests = 0;
    int            fails = 0;
    int            we_cnt = 0;
    int            en_cnt = 0;
    int            both_hi = 0;
    int            we0, en0;
    bit            first_b;
    logic [AW-1:0] first_addr, second_addr;
    logic [DW-1:0] first_data, second_data;

    always #5 clock = ~clock;

    ram_access_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .req_a_in       (req_a_in),
        .req_b_in       (req_b_in),
        .we_a_in        (we_a_in),
        .we_b_in        (we_b_in),
        .addr_a_in      (addr_a_in),
        .addr_b_in      (addr_b_in),
        .wdata_a_in     (wdata_a_in),
        .wdata_b_in     (wdata_b_in),
        .gnt_a_out      (gnt_a_out),
        .gnt_b_out      (gnt_b_out),
        .done_a_out     (done_a_out),
        .done_b_out     (done_b_out),
        .rdata_a_out    (rdata_a_out),
        .rdata_b_out    (rdata_b_out),
        .ram_we_out     (ram_we_out),
        .ram_enable_out (ram_enable_out),
        .ram_addr_out   (ram_addr_out),
        .ram_data       (ram_data)
    );

    // RAM drives on enable; otherwise the probe pulls the bus to 0 to expose a stray driver
    assign ram_data = ram_enable_out ? mem[ram_addr_out] : (probe_en ? 8'h00 : 8'hzz);

    // RAM write and strobe bookkeeping, sampled mid-cycle
    always @(negedge clock) begin
        if (ram_we_out) begin
            mem[ram_addr_out] <= ram_data;
            we_cnt <= we_cnt + 1;
        end
        if (ram_enable_out) en_cnt <= en_cnt + 1;
        if (ram_we_out && ram_enable_out) both_hi <= both_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_bus_z(input string tag);
        probe_en = 1'b1;
        #1;
        chk(tag, 32'(ram_data), 32'd0);
        probe_en = 1'b0;
        #1;
    endtask

    // From SETUP (just after accept) through the return to IDLE; owner drops req after done
    task automatic finish_txn(input bit is_b, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input string tag);
        step();
        chk({tag, "_strobe"}, 32'({ram_we_out, ram_enable_out}), we ? 32'd2 : 32'd1);
        chk({tag, "_saddr"}, 32'(ram_addr_out), 32'(addr));
        chk({tag, "_sbus"}, 32'(ram_data), 32'(data));
        step();
        chk({tag, "_hold"}, 32'({ram_we_out, ram_enable_out}), 32'd0);
        if (we) chk({tag, "_hbus"}, 32'(ram_data), 32'(data));
        else    chk({tag, "_rdata"}, 32'(is_b ? rdata_b_out : rdata_a_out), 32'(data));
        step();
        chk({tag, "_done"}, 32'({gnt_a_out, gnt_b_out, done_a_out, done_b_out}),
            is_b ? 32'h5 : 32'hA);
        chk_bus_z({tag, "_dbus"});
        if (is_b) req_b_in = 1'b0; else req_a_in = 1'b0;
        step();
        chk({tag, "_idle"}, 32'({gnt_a_out, gnt_b_out, done_a_out, done_b_out}), 32'd0);
        chk_bus_z({tag, "_ibus"});
    endtask

    task automatic txn(input bit is_b, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input string tag);
        if (is_b) begin
            req_b_in = 1'b1; we_b_in = we; addr_b_in = addr; wdata_b_in = data;
        end else begin
            req_a_in = 1'b1; we_a_in = we; addr_a_in = addr; wdata_a_in = data;
        end
        step();
        chk({tag, "_gnt"}, 32'({gnt_a_out, gnt_b_out}), is_b ? 32'd1 : 32'd2);
        finish_txn(is_b, we, addr, data, tag);
    endtask

    initial begin
`ifdef RAM_ARB_RR_EN
        first_b = 1'b1;
`else
        first_b = 1'b0;
`endif
        reset = 1'b1;
        req_a_in = 1'b0; req_b_in = 1'b0; we_a_in = 1'b0; we_b_in = 1'b0;
        addr_a_in = '0; addr_b_in = '0; wdata_a_in = '0; wdata_b_in = '0;
        step();
        step();
        chk("rst_ctl", 32'({gnt_a_out, gnt_b_out, done_a_out, done_b_out,
                            ram_we_out, ram_enable_out}), 32'd0);
        chk("rst_addr", 32'(ram_addr_out), 32'd0);
        chk("rst_rdata", 32'({rdata_a_out, rdata_b_out}), 32'd0);
        chk_bus_z("rst_bus");
        reset = 1'b0;
        step();

        // A writes 0x5A to 3; command inputs change one cycle after accept
        we0 = we_cnt; en0 = en_cnt;
        req_a_in = 1'b1; we_a_in = 1'b1; addr_a_in = 4'd3; wdata_a_in = 8'h5A;
        step();
        chk("t1_gnt", 32'({gnt_a_out, gnt_b_out}), 32'd2);
        chk("t1_setup_strb", 32'({ram_we_out, ram_enable_out}), 32'd0);
        chk("t1_setup_addr", 32'(ram_addr_out), 32'd3);
        chk("t1_setup_bus", 32'(ram_data), 32'h5A);
        addr_a_in = 4'd9; wdata_a_in = 8'h11;
        finish_txn(1'b0, 1'b1, 4'd3, 8'h5A, "t1_wr");
        chk("t1_we_cycles", 32'(we_cnt - we0), 32'd1);
        chk("t1_en_cycles", 32'(en_cnt - en0), 32'd0);
        chk("t1_mem3", 32'(mem[3]), 32'h5A);
        // B reads it back
        txn(1'b1, 1'b0, 4'd3, 8'h5A, "t1_rd");
        chk("t1_rdata_a_untouched", 32'(rdata_a_out), 32'd0);

        // Simultaneous reads of addr 7 after reset
        txn(1'b0, 1'b1, 4'd7, 8'h77, "t2_wr7");
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_a_in = 1'b1; we_a_in = 1'b0; addr_a_in = 4'd7;
        req_b_in = 1'b1; we_b_in = 1'b0; addr_b_in = 4'd7;
        step();
        chk("t2_first", 32'({gnt_a_out, gnt_b_out}), 32'd2);
        finish_txn(1'b0, 1'b0, 4'd7, 8'h77, "t2_a");
        step();
        chk("t2_second", 32'({gnt_a_out, gnt_b_out}), 32'd1);
        finish_txn(1'b1, 1'b0, 4'd7, 8'h77, "t2_b");
        // A alone, then a repeated tie
        txn(1'b0, 1'b0, 4'd3, 8'h5A, "t2_solo");
        req_a_in = 1'b1; we_a_in = 1'b0; addr_a_in = 4'd7;
        req_b_in = 1'b1; we_b_in = 1'b0; addr_b_in = 4'd3;
        first_addr  = first_b ? 4'd3 : 4'd7;
        first_data  = first_b ? 8'h5A : 8'h77;
        second_addr = first_b ? 4'd7 : 4'd3;
        second_data = first_b ? 8'h77 : 8'h5A;
        step();
        chk("t2_rep_first", 32'({gnt_a_out, gnt_b_out}), first_b ? 32'd1 : 32'd2);
        finish_txn(first_b, 1'b0, first_addr, first_data, "t2_rep1");
        step();
        chk("t2_rep_second", 32'({gnt_a_out, gnt_b_out}), first_b ? 32'd2 : 32'd1);
        finish_txn(!first_b, 1'b0, second_addr, second_data, "t2_rep2");

        // Boundary addresses and data
        txn(1'b0, 1'b1, 4'd15, 8'hFF, "t3_wr15");
        txn(1'b0, 1'b1, 4'd0, 8'h01, "t3_wr0");
        txn(1'b1, 1'b0, 4'd15, 8'hFF, "t3_rd15");
        txn(1'b1, 1'b0, 4'd0, 8'h01, "t3_rd0");

        // Reset during a write strobe aborts the access
        req_a_in = 1'b1; we_a_in = 1'b1; addr_a_in = 4'd5; wdata_a_in = 8'h33;
        step();
        step();
        chk("t4_strobe", 32'({ram_we_out, ram_enable_out}), 32'd2);
        reset = 1'b1;
        step();
        chk("t4_rst_strb", 32'({ram_we_out, ram_enable_out}), 32'd0);
        chk("t4_rst_ctl", 32'({gnt_a_out, gnt_b_out, done_a_out, done_b_out}), 32'd0);
        chk_bus_z("t4_rst_bus");
        reset = 1'b0; req_a_in = 1'b0;
        req_b_in = 1'b1; we_b_in = 1'b0; addr_b_in = 4'd3;
        step();
        chk("t4_idle_accept", 32'({gnt_a_out, gnt_b_out, done_a_out, done_b_out}), 32'd4);
        finish_txn(1'b1, 1'b0, 4'd3, 8'h5A, "t4_rd");

        // A held continuously: accepts at E0, E5, E10; B joins during the second access
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_a_in = 1'b1; we_a_in = 1'b0; addr_a_in = 4'd7;
        step();
        chk("t6_e0", 32'({gnt_a_out, gnt_b_out}), 32'd2);
        step(); step(); step();
        chk("t6_d0", 32'({gnt_a_out, gnt_b_out, done_a_out, done_b_out}), 32'hA);
        step();
        chk("t6_i0", 32'({gnt_a_out, gnt_b_out, done_a_out, done_b_out}), 32'd0);
        step();
        chk("t6_e5", 32'({gnt_a_out, gnt_b_out}), 32'd2);
        req_b_in = 1'b1; we_b_in = 1'b0; addr_b_in = 4'd15;
        step(); step(); step();
        chk("t6_d5", 32'({gnt_a_out, gnt_b_out, done_a_out, done_b_out}), 32'hA);
        chk("t6_rdata5", 32'(rdata_a_out), 32'h77);
        step();
        chk("t6_i5", 32'({gnt_a_out, gnt_b_out, done_a_out, done_b_out}), 32'd0);
        first_addr  = first_b ? 4'd15 : 4'd7;
        first_data  = first_b ? 8'hFF : 8'h77;
        second_addr = first_b ? 4'd7 : 4'd15;
        second_data = first_b ? 8'h77 : 8'hFF;
        step();
        chk("t6_e10", 32'({gnt_a_out, gnt_b_out}), first_b ? 32'd1 : 32'd2);
        finish_txn(first_b, 1'b0, first_addr, first_data, "t6_10");
        step();
        chk("t6_e15", 32'({gnt_a_out, gnt_b_out}), first_b ? 32'd2 : 32'd1);
        finish_txn(!first_b, 1'b0, second_addr, second_data, "t6_15");

        chk("strobe_overlap", 32'(both_hi), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
